// File: rtl/dram_arbiter.sv
// -----------------------------------------------------------------------------
// dram_arbiter
//
// Shares one single-port data RAM among NCORES cores. Requests are granted
// round-robin, and only one RAM transaction is in flight at a time. Each core
// waits until its acq bit pulses. Read data goes back to the requesting core
// through a per-core holding register.
//
// Transaction sequence: IDLE -> ACCESS -> (WAIT x RD_LAT, reads only) -> DONE.
//
// Ports
//   CLK         system clock, rising edge
//   rst         asynchronous reset, active-low
//   rden/wren   per-core read / write requests (bit i = core i)
//   Address     per-core address, core i at [i*AW +: AW]
//   Din         per-core write data, core i at [i*DW +: DW]
//   RAMq        RAM read data, valid RD_LAT clocks after the address edge
//   acq         one-hot completion strobe, high for one cycle
//   Dq          per-core read-data registers, core i at [i*DW +: DW]
//   RAMAddress  registered RAM address
//   RAMDin      registered RAM write data
//   RAMwren     registered RAM write enable
//   busy        high whenever a transaction is being sequenced
// -----------------------------------------------------------------------------
module dram_arbiter #(
  parameter int NCORES = 2,
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic [NCORES-1:0]    rden,
  input  logic [NCORES-1:0]    wren,
  input  logic [NCORES*AW-1:0] Address,
  input  logic [NCORES*DW-1:0] Din,
  input  logic [DW-1:0]        RAMq,
  output logic [NCORES-1:0]    acq,
  output logic [NCORES*DW-1:0] Dq,
  output logic [AW-1:0]        RAMAddress,
  output logic [DW-1:0]        RAMDin,
  output logic                 RAMwren,
  output logic                 busy
);

  // Width of a core index and of the read-latency counter.
  localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  state_t              state;
  op_t                 op;
  logic [IW-1:0]       g;      // core owning the current transaction
  logic [IW-1:0]       last;   // most recently completed core
  logic [CW-1:0]       cnt;    // read-latency counter inside WAIT

  logic [NCORES-1:0]   req;
  logic [IW-1:0]       pick;
  logic                found;
  logic [NCORES-1:0]   grant_mask;

  assign req  = rden | wren;
  assign busy = (state != IDLE);

  // Round-robin pick. The scan starts at the core after the last one served
  // and wraps, so the core just served has the lowest priority.
  // NOTE: every variable assigned in an always_comb gets a default before any
  // conditional assignment. Without the default a latch would be inferred.
  always_comb begin
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= NCORES; k++) begin
      if (!found && req[(int'(last) + k) % NCORES]) begin
        found = 1'b1;
        pick  = IW'((int'(last) + k) % NCORES);
      end
    end
  end

  always_comb begin
    grant_mask    = '0;
    grant_mask[g] = 1'b1;
  end

  // Sequencer. Each transaction runs to completion even if the core drops its
  // request part-way through. Address, Din and wren are sampled only in IDLE.
  // A core that asserts both rden and wren gets a write, so its Dq is untouched.
  // NOTE: sequential state is updated with non-blocking assignments only. Every
  // register then sees the pre-edge values of the others, which matches the
  // behaviour of the flops.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      op         <= OP_READ;
      g          <= '0;
      last       <= IW'(NCORES - 1);
      cnt        <= '0;
      acq        <= '0;
      // NOTE: the read-data registers are reset as well. They are visible
      // outputs that cores may sample, so they must not power up unknown.
      Dq         <= '0;
      RAMAddress <= '0;
      RAMDin     <= '0;
      RAMwren    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          acq <= '0;
          if (found) begin
            g          <= pick;
            RAMAddress <= Address[pick*AW +: AW];
            RAMDin     <= Din[pick*DW +: DW];
            RAMwren    <= wren[pick];
            op         <= wren[pick] ? OP_WRITE : OP_READ;
            state      <= ACCESS;
          end
        end

        // The RAM samples address, data and write enable at the edge that
        // closes this cycle. RAMwren is dropped at that edge, so a write
        // strobe lasts exactly one cycle.
        ACCESS: begin
          RAMwren <= 1'b0;
          cnt     <= '0;
          if (op == OP_WRITE) begin
            acq   <= grant_mask;
            state <= DONE;
          end else begin
            state <= WAIT;
          end
        end

        // RAMq becomes valid RD_LAT clocks after the address-sampling edge.
        // It is captured on the edge where cnt has counted RD_LAT-1.
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(RD_LAT - 1)) begin
            Dq[g*DW +: DW] <= RAMq;
            acq            <= grant_mask;
            state          <= DONE;
          end
        end

        DONE: begin
          acq   <= '0;
          last  <= g;
          state <= IDLE;
        end

        default: begin
          acq     <= '0;
          RAMwren <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dram_arbiter
//
// Directed bench for dram_arbiter. u_dut uses RD_LAT=1 and u_dut2 uses
// RD_LAT=2. Each DUT has its own behavioural RAM with the matching read
// latency. Expected values are written by hand from the transaction timing.
// -----------------------------------------------------------------------------
module tb_dram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        preload;

  // u_dut (RD_LAT = 1)
  logic [1:0]  rden, wren;
  logic [15:0] address, din;
  logic [7:0]  ram_q;
  logic [1:0]  acq;
  logic [15:0] dq;
  logic [7:0]  ram_address, ram_din;
  logic        ram_wren, busy;

  // u_dut2 (RD_LAT = 2)
  logic [1:0]  rden2, wren2;
  logic [15:0] address2, din2;
  logic [7:0]  ram_q2, ram_q2a;
  logic [1:0]  acq2;
  logic [15:0] dq2;
  logic [7:0]  ram_address2, ram_din2;
  logic        ram_wren2, busy2;

  logic [7:0]  mem1 [256];
  logic [7:0]  mem2 [256];

  int vectors;
  int miscompares;

  dram_arbiter #(.NCORES(2), .AW(8), .DW(8), .RD_LAT(1)) u_dut (
    .CLK        (clk),
    .rst        (rst_n),
    .rden       (rden),
    .wren       (wren),
    .Address    (address),
    .Din        (din),
    .RAMq       (ram_q),
    .acq        (acq),
    .Dq         (dq),
    .RAMAddress (ram_address),
    .RAMDin     (ram_din),
    .RAMwren    (ram_wren),
    .busy       (busy)
  );

  dram_arbiter #(.NCORES(2), .AW(8), .DW(8), .RD_LAT(2)) u_dut2 (
    .CLK        (clk),
    .rst        (rst_n),
    .rden       (rden2),
    .wren       (wren2),
    .Address    (address2),
    .Din        (din2),
    .RAMq       (ram_q2),
    .acq        (acq2),
    .Dq         (dq2),
    .RAMAddress (ram_address2),
    .RAMDin     (ram_din2),
    .RAMwren    (ram_wren2),
    .busy       (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM with 1-cycle read latency.
  always @(posedge clk) begin
    if (preload) begin
      mem1[8'h10] <= 8'h5A;
      mem1[8'h01] <= 8'h11;
      mem1[8'h02] <= 8'h22;
      mem1[8'h50] <= 8'h99;
    end else if (ram_wren) begin
      mem1[ram_address] <= ram_din;
    end
    ram_q <= mem1[ram_address];
  end

  // RAM with 2-cycle read latency.
  always @(posedge clk) begin
    if (preload) begin
      mem2[8'h10] <= 8'h5A;
    end else if (ram_wren2) begin
      mem2[ram_address2] <= ram_din2;
    end
    ram_q2a <= mem2[ram_address2];
    ram_q2  <= ram_q2a;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Clocks u_dut until acq rises, with a bound of 12 cycles. Then it checks
  // the strobe value and the cycle count, counted from the latching edge.
  task automatic run_until_acq(input string tag, input logic [1:0] exp_acq,
                               input int exp_n);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (acq == 2'b00 && n < 12);
    check({tag, "_acq"}, 32'(acq), 32'(exp_acq));
    check({tag, "_lat"}, 32'(n), 32'(exp_n));
  endtask

  initial begin
    int n;
    vectors     = 0;
    miscompares = 0;
    rst_n   = 1'b0;
    preload = 1'b1;
    rden  = '0; wren  = '0; address  = '0; din  = '0;
    rden2 = '0; wren2 = '0; address2 = '0; din2 = '0;

    // Reset state
    step();
    step();
    check("rst_acq",   32'(acq),         32'h0);
    check("rst_dq",    32'(dq),          32'h0);
    check("rst_addr",  32'(ram_address), 32'h0);
    check("rst_wren",  32'(ram_wren),    32'h0);
    check("rst_busy",  32'(busy),        32'h0);
    check("rst_busy2", 32'(busy2),       32'h0);
    preload = 1'b0;
    rst_n   = 1'b1;
    step();

    // Single read by core 0 of address 0x10
    rden = 2'b01;
    address[7:0] = 8'h10;
    step();                                       // latch edge
    check("rd_addr",  32'(ram_address), 32'h10);
    check("rd_busy",  32'(busy),        32'h1);
    check("rd_acq1",  32'(acq),         32'h0);
    step();
    check("rd_acq2",  32'(acq),         32'h0);
    step();
    check("rd_acq3",  32'(acq),         32'h1);
    check("rd_dq0",   32'(dq[7:0]),     32'h5A);
    rden = 2'b00;
    step();
    check("rd_acq4",  32'(acq),         32'h0);
    check("rd_idle",  32'(busy),        32'h0);

    // Single write by core 1: 0xC3 to 0x20
    wren = 2'b10;
    address[15:8] = 8'h20;
    din[15:8]     = 8'hC3;
    step();
    check("wr_wren1", 32'(ram_wren),    32'h1);
    check("wr_addr",  32'(ram_address), 32'h20);
    check("wr_din",   32'(ram_din),     32'hC3);
    check("wr_acq1",  32'(acq),         32'h0);
    step();
    check("wr_wren2", 32'(ram_wren),    32'h0);
    check("wr_acq2",  32'(acq),         32'h2);
    check("wr_mem",   32'(mem1[8'h20]), 32'hC3);
    wren = 2'b00;
    step();
    check("wr_acq3",  32'(acq),         32'h0);

    // Core 1 reads the value back
    rden = 2'b10;
    run_until_acq("rdback", 2'b10, 3);
    check("rdback_dq1", 32'(dq[15:8]), 32'hC3);
    rden = 2'b00;
    step();

    // Contention after reset: core 0 first, then core 1
    rst_n = 1'b0;
    step();
    check("rst2_dq", 32'(dq), 32'h0);
    rst_n = 1'b1;
    rden    = 2'b11;
    address = {8'h02, 8'h01};
    run_until_acq("cont0", 2'b01, 3);
    rden = 2'b10;
    run_until_acq("cont1", 2'b10, 4);
    check("cont_dq", 32'(dq), 32'h2211);
    rden = 2'b00;
    step();
    check("cont_acq_off", 32'(acq), 32'h0);

    // Sustained write contention: grants alternate 0,1,0,1,...
    wren    = 2'b11;
    address = {8'h31, 8'h30};
    din     = {8'hB1, 8'hA0};
    for (int i = 0; i < 8; i++) begin
      n = 0;
      do begin
        step();
        n++;
      end while (acq == 2'b00 && n < 12);
      check($sformatf("rr%0d_acq", i), 32'(acq), (i % 2 == 0) ? 32'h1 : 32'h2);
      check($sformatf("rr%0d_gap", i), 32'(n),   (i == 0) ? 32'd2 : 32'd3);
    end
    wren = 2'b00;
    step();
    check("rr_mem0", 32'(mem1[8'h30]), 32'hA0);
    check("rr_mem1", 32'(mem1[8'h31]), 32'hB1);

    // rden+wren on one core acts as a write; Dq keeps 0x5A
    rden = 2'b01;
    address[7:0] = 8'h10;
    run_until_acq("pre5a", 2'b01, 3);
    check("pre5a_dq0", 32'(dq[7:0]), 32'h5A);
    rden = 2'b00;
    step();
    rden = 2'b01;
    wren = 2'b01;
    address[7:0] = 8'h40;
    din[7:0]     = 8'h77;
    run_until_acq("rw", 2'b01, 2);
    check("rw_dq0", 32'(dq[7:0]),     32'h5A);
    check("rw_mem", 32'(mem1[8'h40]), 32'h77);
    rden = 2'b00;
    wren = 2'b00;
    step();

    // RD_LAT=2 instance: read of 0x10, acq 4 cycles after latch
    rden2 = 2'b01;
    address2[7:0] = 8'h10;
    n = 0;
    do begin
      step();
      n++;
    end while (acq2 == 2'b00 && n < 12);
    check("lat2_acq", 32'(acq2),     32'h1);
    check("lat2_lat", 32'(n),        32'd4);
    check("lat2_dq0", 32'(dq2[7:0]), 32'h5A);
    rden2 = 2'b00;
    step();
    check("lat2_acq_off", 32'(acq2), 32'h0);

    // Reset while a write is in ACCESS: the write must never reach RAM
    wren = 2'b10;
    address[15:8] = 8'h50;
    din[15:8]     = 8'hEE;
    step();
    check("mid_wren_on", 32'(ram_wren), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_wren_off", 32'(ram_wren), 32'h0);
    check("mid_acq",      32'(acq),      32'h0);
    check("mid_busy",     32'(busy),     32'h0);
    wren = 2'b00;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    check("mid_mem",   32'(mem1[8'h50]), 32'h99);
    check("mid_wren2", 32'(ram_wren),    32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Shares the single-port data RAM (DRAM) between NCORES processor cores so that each core's data-memory access completes in turn.
- Sits between the cores' data-memory ports and DRAM.
- Arbitrates round-robin, sequences one RAM transaction at a time, and drives each core's acq stall/proceed strobe.
- Returns read data to the requesting core through a per-core held register.

Parameters:
- NCORES, 2, number of requesting cores.
- AW, 8, address width.
- DW, 8, data width.
- RD_LAT, 1, DRAM read latency in clocks from the address-sampling edge to valid q (1 to 3).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- rden  input  NCORES  per-core read request; bit i belongs to core i.
- wren  input  NCORES  per-core write request.
- Address  input  NCORES*AW  per-core address; core i occupies [i*AW +: AW].
- Din  input  NCORES*DW  per-core write data; core i occupies [i*DW +: DW].
- RAMq  input  DW  DRAM read data.
- acq  output  NCORES  one-hot completion strobe; core i proceeds when acq[i]=1.
- Dq  output  NCORES*DW  per-core read-data registers; core i occupies [i*DW +: DW].
- RAMAddress  output  AW  DRAM address, registered.
- RAMDin  output  DW  DRAM write data, registered.
- RAMwren  output  1  DRAM write enable, registered.
- busy  output  1  high in every state other than IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, acq=0, Dq=0, RAMAddress=0, RAMDin=0, RAMwren=0, last=NCORES-1 (so core 0 has first priority), cnt=0.
- Request definition: req[i] = rden[i] | wren[i].
- IDLE:
  - If any req bit is set, select the first requester scanning from last+1, wrapping modulo NCORES, and latch it as g.
  - At the same edge, latch RAMAddress<=Address[g], RAMDin<=Din[g], RAMwren<=wren[g], op<=wren[g] ? WRITE : READ; go to ACCESS.
  - Otherwise remain in IDLE.
- ACCESS (1 cycle): DRAM samples address, data and write enable at the closing edge. At that edge RAMwren<=0.
  - WRITE: go to DONE.
  - READ: go to WAIT with cnt<=0.
- WAIT (RD_LAT cycles): cnt increments each cycle. On the edge where cnt==RD_LAT-1, capture Dq[g]<=RAMq and go to DONE.
- DONE (1 cycle): acq[g]=1 (registered, one-hot); last<=g; go to IDLE. acq is 0 in every other state.
- Completion latency, counted from the edge that latches the request:
  - Write: acq high in the 2nd cycle after that edge.
  - Read: acq high in the (RD_LAT+2)th cycle after that edge.
- Occupancy per transaction, including the IDLE cycle:
  - Write: 3 cycles.
  - Read: RD_LAT+3 cycles.
- Request/data holding rules:
  - Cores hold requests until acq.
  - Address and Din are sampled only in IDLE; later changes do not affect the transaction.
  - A request withdrawn mid-transaction does not abort it; it completes and acq still pulses.
- rden and wren both set on one core: treated as a write; Dq for that core is unchanged.
- Dq[i] changes only on a completed read by core i. It holds its value indefinitely otherwise, including while other cores are served.
- Fairness: with all cores requesting continuously, grants rotate 0,1,...,NCORES-1,0,... A single requester is re-granted after each IDLE cycle.
- Non-selected cores see acq=0 and stay stalled.
- Reset mid-transaction: immediate return to IDLE with RAMwren forced to 0. A partially sequenced write must not be issued after reset release.

Test Plan:
- Single read, RD_LAT=1, RAM model holding 0x5A at address 0x10; core0 rden=1, Address=0x10 -> RAMAddress=0x10 one cycle after latch; acq=2'b01 for exactly one cycle, 3 cycles after latch; Dq[7:0]=0x5A.
- Single write: core1 wren=1, Address=0x20, Din=0xC3 -> RAMwren high for exactly one cycle with RAMAddress=0x20 and RAMDin=0xC3; acq=2'b10 two cycles after latch; subsequent core1 read of 0x20 returns 0xC3.
- Contention after reset: both cores read simultaneously (0x01=0x11, 0x02=0x22) -> core0 served first (acq=01), then core1 (acq=10); Dq=={0x22,0x11}; exactly one acq bit high at any time.
- Sustained contention over 8 transactions -> grant order 0,1,0,1,...; no core served twice in a row while the other is requesting.
- Same core asserts rden=1 and wren=1 with Din=0x77 and prior Dq=0x5A -> write of 0x77 performed; Dq stays 0x5A.
- RD_LAT=2 rebuild: read of address 0x10 -> acq 4 cycles after latch with correct data.
- Reset mid-transaction: rst low during ACCESS of a write -> RAMwren=0 immediately; acq=0, busy=0; target RAM location is unchanged after reset release.
